axi4_r_drop_responder: RTL and testbench
========================================

# axi4_r_drop_responder

Read-data (R) channel responder for the RAB slave port. It forwards R beats from the downstream master port to the upstream slave port unchanged. When the address path has dropped a read, for example on a RAB miss or a protection violation, it synthesises the complete SLVERR response burst with the dropped transaction's ID and length. Bursts are never interleaved at beat level. It is the read-direction counterpart of the W-channel buffering on the write path.

## Interface
- AXI_DATA_WIDTH, 32, R data width
- AXI_ID_WIDTH, 4, R ID width
- AXI_USER_WIDTH, 2, R user width
- DROP_DEPTH, 4, drop-request queue entries (power of 2, ≥2)

Clock and reset: one clock; reset is synchronous and active-high.

- axi4_aclk  in  1  clock
- axi4_arst  in  1  synchronous active-high reset
- drop_valid_i  in  1  push a dropped-read descriptor
- drop_ready_o  out  1  queue not full
- drop_id_i  in  AXI_ID_WIDTH  ID of dropped read
- drop_len_i  in  8  AXI len of dropped read (beats−1)
- drop_user_i  in  AXI_USER_WIDTH  user bits returned on error beats
- drop_done_o  out  1  one-cycle pulse: error burst completed
- s_axi4_rid / rdata / rresp / rlast / ruser  out  ID / DATA / 2 / 1 / USER  upstream R payload
- s_axi4_rvalid  out  1  upstream R valid
- s_axi4_rready  in  1  upstream R ready
- m_axi4_rid / rdata / rresp / rlast / ruser  in  ID / DATA / 2 / 1 / USER  downstream R payload
- m_axi4_rvalid  in  1  downstream R valid
- m_axi4_rready  out  1  downstream R ready

## Operation
**Drop queue.** Synchronous FIFO of {id, len, user}.
- A push occurs when drop_valid_i && drop_ready_o.
- drop_ready_o = !full, computed from registered state only. A pop in the same cycle does not free a slot until the next cycle.

**FSM.**
- IDLE:
  - If the queue is non-empty: m_axi4_rready=0 and s_axi4_rvalid=0. Load beat counter cnt=0. Go to ERR.
  - Else, combinational passthrough: s_axi4_r* = m_axi4_r*, m_axi4_rready = s_axi4_rready.
  - A passthrough handshake with rlast=0 goes to PASS. A handshake with rlast=1 stays in IDLE.
- PASS: passthrough as in IDLE, regardless of queue state. A handshake with rlast=1 goes to IDLE.
- ERR:
  - m_axi4_rready=0 and s_axi4_rvalid=1.
  - Payload: rid = head.id, rresp = 2'b10 (SLVERR), rdata = 0, ruser = head.user, rlast = (cnt == head.len).
  - Each handshake increments cnt.
  - A handshake with rlast=1 pops the queue and goes to IDLE.
- cnt is 8 bits. len=255 gives 256 beats with no overflow, because cnt is never incremented past len.

**Boundary rules.**
- len=0: a single error beat with rlast=1.
- A push into an empty queue during a passthrough handshake without rlast: PASS takes precedence. The error burst starts only after that burst's rlast.
- Back-to-back queued drops: IDLE is re-entered for exactly one cycle between error bursts. During that cycle no passthrough occurs.
- s_axi4_rready low in ERR: the payload holds stable and s_axi4_rvalid stays high.
- Reset mid-burst: the burst is abandoned, the queue is flushed, and the FSM returns to IDLE. Clearing the upstream side is the system's responsibility.

## Timing
- Reset values while axi4_arst is high: state IDLE, queue empty, cnt 0.
- Outputs while axi4_arst is high:
  - all s_axi4_* outputs = 0
  - m_axi4_rready = 0
  - drop_ready_o = 0
  - drop_done_o = 0
- Outputs return to normal behaviour in the first cycle after reset is deasserted.
- Passthrough: zero latency, purely combinational, no added register.
- Error burst: the first error beat is valid 2 cycles after a push accepted into an empty queue in IDLE (cycle 1: queue non-empty, IDLE→ERR; cycle 2: beat valid).
- Error burst throughput: one beat per cycle while s_axi4_rready=1.
- drop_done_o: registered, high for exactly one cycle, the cycle after the last error beat's handshake.

## Structure
- Shared package rab_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - state enum {IDLE, PASS, ERR}
  - drop descriptor struct {id, len, user}, parameterised via localparams
- Sub-module rab_sync_fifo:
  - generic synchronous FIFO, parameters WIDTH and DEPTH
  - ports: push/pop, full/empty, head data
  - synchronous active-high reset
  - also reused by the write-side drop logic

## Test plan
- Passthrough: 4-beat burst from m, id=3, rready always 1 → identical beats on s in the same cycles; rlast on beat 4; drop_done_o stays 0.
- Single drop: id=5, len=0, user=2'b01 → 2 cycles later one beat: rid=5, rresp=2'b10, rdata=0, rlast=1; drop_done_o pulses the next cycle.
- Long drop with backpressure: len=255, s_axi4_rready toggled randomly → exactly 256 beats; rlast only on beat 256; payload stable while stalled.
- Drop during an active passthrough burst:
  - stimulus: push id=7, len=1 after beat 1 of a 4-beat m burst
  - required: the m burst completes uninterrupted, then 2 error beats with id=7
  - required: m_axi4_rready=0 throughout the error burst
- Queue full: push 4 descriptors with s_axi4_rready=0 → drop_ready_o=0 after the 4th push; a 5th push is refused; all 4 bursts are returned in FIFO order.
- Reset in ERR: assert axi4_arst at beat 3 of a len=7 burst → all outputs 0 during reset; after release: state IDLE, queue empty, passthrough works.

Source files
------------

// File: rtl/rab_pkg.sv
// Shared definitions for the RAB read/write drop responders.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: AXI response codes, responder FSM state encoding and the
// default-width dropped-transaction descriptor.
package rab_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int DEF_ID_WIDTH   = 4;
   localparam int DEF_USER_WIDTH = 2;
   localparam int LEN_WIDTH      = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      ERR  = 2'd2
   } r_state_e;

   typedef struct packed {
      logic [DEF_ID_WIDTH-1:0]   id;
      logic [LEN_WIDTH-1:0]      len;
      logic [DEF_USER_WIDTH-1:0] user;
   } drop_desc_t;

endpackage

// File: rtl/axi4_r_drop_responder_if.sv
// AXI4 read-data (R) channel bundle.
// Latency: n/a (wires only).
// Backpressure: rready from the master side, rvalid/payload from the slave side.
//
// Modports: slave drives the R payload and rvalid and samples rready;
// master samples the payload and drives rready.
interface axi4_r_drop_responder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int USER_WIDTH = 2
);
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic [USER_WIDTH-1:0] ruser;
   logic                  rvalid;
   logic                  rready;

   modport master (
      input  rid, rdata, rresp, rlast, ruser, rvalid,
      output rready
   );

   modport slave (
      output rid, rdata, rresp, rlast, ruser, rvalid,
      input  rready
   );
endinterface

// File: rtl/rab_sync_fifo.sv
// Generic synchronous FIFO with head-of-queue visibility.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: full/empty are from registered state; push when full and pop when empty are ignored.
//
// Ports: clk, rst (sync active-high), push/push_dat, pop, head_dat, full, empty.
module rab_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; occupancy is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/axi4_r_drop_responder.sv
// R-channel responder: forwards downstream R beats and synthesises SLVERR bursts for dropped reads.
// Latency: passthrough combinational (0 cycles); first error beat 2 cycles after a push into an empty queue.
// Backpressure: s_axi4.rready is forwarded to m_axi4.rready in passthrough; error beats hold while rready is low.
//
// Ports: axi4_aclk, axi4_arst (sync active-high), drop_* descriptor push and
// completion pulse, s_axi4 (upstream R, slave modport), m_axi4 (downstream R,
// master modport). All outputs are forced to zero while reset is asserted.
module axi4_r_drop_responder
   import rab_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_USER_WIDTH = 2,
   parameter int DROP_DEPTH     = 4
) (
   input  logic                      axi4_aclk,
   input  logic                      axi4_arst,
   input  logic                      drop_valid_i,
   output logic                      drop_ready_o,
   input  logic [AXI_ID_WIDTH-1:0]   drop_id_i,
   input  logic [7:0]                drop_len_i,
   input  logic [AXI_USER_WIDTH-1:0] drop_user_i,
   output logic                      drop_done_o,
   axi4_r_drop_responder_if.slave    s_axi4,
   axi4_r_drop_responder_if.master   m_axi4
);
   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [7:0]                len;
      logic [AXI_USER_WIDTH-1:0] user;
   } drop_entry_t;

   drop_entry_t head;
   drop_entry_t push_entry;
   logic        q_full;
   logic        q_empty;
   logic        q_push;
   logic        q_pop;

   r_state_e    state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        done_q, done_d;

   logic [AXI_ID_WIDTH-1:0]   out_id;
   logic [AXI_DATA_WIDTH-1:0] out_data;
   logic [1:0]                out_resp;
   logic                      out_last;
   logic [AXI_USER_WIDTH-1:0] out_user;
   logic                      out_vld;
   logic                      in_rdy;

   assign push_entry = '{id: drop_id_i, len: drop_len_i, user: drop_user_i};
   assign q_push     = drop_valid_i && drop_ready_o;

   rab_sync_fifo #(
      .WIDTH ($bits(drop_entry_t)),
      .DEPTH (DROP_DEPTH)
   ) u_drop_q (
      .clk      (axi4_aclk),
      .rst      (axi4_arst),
      .push     (q_push),
      .push_dat (push_entry),
      .pop      (q_pop),
      .head_dat (head),
      .full     (q_full),
      .empty    (q_empty)
   );

   always_ff @(posedge axi4_aclk) begin
      if (axi4_arst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      q_pop    = 1'b0;
      out_id   = m_axi4.rid;
      out_data = m_axi4.rdata;
      out_resp = m_axi4.rresp;
      out_last = m_axi4.rlast;
      out_user = m_axi4.ruser;
      out_vld  = m_axi4.rvalid;
      in_rdy   = s_axi4.rready;

      unique case (state_q)
         IDLE: begin
            // A pending drop wins over new downstream bursts; this also gives
            // the single dead cycle between back-to-back error bursts.
            if (!q_empty) begin
               out_vld = 1'b0;
               in_rdy  = 1'b0;
               cnt_d   = '0;
               state_d = ERR;
            end else if (m_axi4.rvalid && s_axi4.rready && !m_axi4.rlast) begin
               state_d = PASS;
            end
         end
         PASS: begin
            // Bursts are never interleaved: stay locked until rlast passes.
            if (m_axi4.rvalid && s_axi4.rready && m_axi4.rlast) begin
               state_d = IDLE;
            end
         end
         ERR: begin
            out_vld  = 1'b1;
            in_rdy   = 1'b0;
            out_id   = head.id;
            out_data = '0;
            out_resp = RESP_SLVERR;
            out_user = head.user;
            out_last = (cnt_q == head.len);
            if (s_axi4.rready) begin
               if (out_last) begin
                  q_pop   = 1'b1;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  // Never passes len, so len=255 cannot wrap the counter.
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign s_axi4.rid    = axi4_arst ? '0 : out_id;
   assign s_axi4.rdata  = axi4_arst ? '0 : out_data;
   assign s_axi4.rresp  = axi4_arst ? '0 : out_resp;
   assign s_axi4.rlast  = axi4_arst ? 1'b0 : out_last;
   assign s_axi4.ruser  = axi4_arst ? '0 : out_user;
   assign s_axi4.rvalid = axi4_arst ? 1'b0 : out_vld;
   assign m_axi4.rready = axi4_arst ? 1'b0 : in_rdy;
   assign drop_ready_o  = !axi4_arst && !q_full;
   assign drop_done_o   = done_q;

endmodule

// File: tb/tb_axi4_r_drop_responder.sv
module tb_axi4_r_drop_responder;
   logic       axi4_aclk = 1'b0;
   logic       axi4_arst;
   logic       drop_valid_i;
   logic       drop_ready_o;
   logic [3:0] drop_id_i;
   logic [7:0] drop_len_i;
   logic [1:0] drop_user_i;
   logic       drop_done_o;

   int checks = 0;
   int errors = 0;

   axi4_r_drop_responder_if s_if ();
   axi4_r_drop_responder_if m_if ();

   axi4_r_drop_responder dut (
      .axi4_aclk    (axi4_aclk),
      .axi4_arst    (axi4_arst),
      .drop_valid_i (drop_valid_i),
      .drop_ready_o (drop_ready_o),
      .drop_id_i    (drop_id_i),
      .drop_len_i   (drop_len_i),
      .drop_user_i  (drop_user_i),
      .drop_done_o  (drop_done_o),
      .s_axi4       (s_if),
      .m_axi4       (m_if)
   );

   always #5 axi4_aclk = ~axi4_aclk;

   typedef struct {
      logic        m_vld;
      logic [3:0]  m_id;
      logic [31:0] m_data;
      logic [1:0]  m_resp;
      logic        m_last;
      logic [1:0]  m_user;
      logic        s_rdy;
      logic        e_vld;
      logic        e_mrdy;
      logic [3:0]  e_id;
      logic [31:0] e_data;
      logic [1:0]  e_resp;
      logic        e_last;
      logic [1:0]  e_user;
   } vec_t;

   vec_t vecs [8];

   function automatic vec_t mk(input logic mv, input logic [3:0] mi, input logic [31:0] md,
                               input logic [1:0] mr, input logic ml, input logic [1:0] mu,
                               input logic sr, input logic ev, input logic em,
                               input logic [3:0] ei, input logic [31:0] ed, input logic [1:0] er,
                               input logic el, input logic [1:0] eu);
      vec_t v;
      v.m_vld = mv; v.m_id = mi; v.m_data = md; v.m_resp = mr; v.m_last = ml; v.m_user = mu;
      v.s_rdy = sr; v.e_vld = ev; v.e_mrdy = em; v.e_id = ei; v.e_data = ed; v.e_resp = er;
      v.e_last = el; v.e_user = eu;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge axi4_aclk);
      #1;
   endtask

   task automatic drive_m(input logic v, input logic [3:0] id, input logic [31:0] d,
                          input logic [1:0] r, input logic l, input logic [1:0] u);
      m_if.rvalid = v; m_if.rid = id; m_if.rdata = d; m_if.rresp = r; m_if.rlast = l; m_if.ruser = u;
   endtask

   task automatic push(input logic [3:0] id, input logic [7:0] len, input logic [1:0] user);
      drop_valid_i = 1'b1; drop_id_i = id; drop_len_i = len; drop_user_i = user;
   endtask

   initial begin
      int beats, cyc, n, first_c, last_c;
      bit got_last;
      logic [3:0] q_ids  [7];
      logic       q_lasts[7];

      // ---------------- reset state ----------------
      axi4_arst = 1'b1;
      drop_valid_i = 1'b1; drop_id_i = 4'h1; drop_len_i = 8'd0; drop_user_i = 2'b11;
      s_if.rready = 1'b1;
      drive_m(1'b1, 4'hF, 32'hFFFF_FFFF, 2'b11, 1'b1, 2'b11);
      #2;
      chk("rst rvalid", s_if.rvalid, 0);
      chk("rst rid", s_if.rid, 0);
      chk("rst rdata", s_if.rdata, 0);
      chk("rst rlast", s_if.rlast, 0);
      chk("rst mrdy", m_if.rready, 0);
      chk("rst drop_ready", drop_ready_o, 0);
      chk("rst done", drop_done_o, 0);
      tick(); tick();
      axi4_arst = 1'b0;
      drop_valid_i = 1'b0;
      drive_m(1'b0, 4'h0, 32'h0, 2'b00, 1'b0, 2'b00);

      // ---------------- table-driven passthrough ----------------
      vecs[0] = mk(0, 4'h0, 32'h0,         2'b00, 0, 2'b00, 1,  0, 1, 4'h0, 32'h0,         2'b00, 0, 2'b00);
      vecs[1] = mk(1, 4'h3, 32'hA000_0001, 2'b00, 0, 2'b10, 1,  1, 1, 4'h3, 32'hA000_0001, 2'b00, 0, 2'b10);
      vecs[2] = mk(1, 4'h3, 32'hA000_0002, 2'b00, 0, 2'b10, 1,  1, 1, 4'h3, 32'hA000_0002, 2'b00, 0, 2'b10);
      vecs[3] = mk(1, 4'h3, 32'hA000_0003, 2'b00, 0, 2'b10, 1,  1, 1, 4'h3, 32'hA000_0003, 2'b00, 0, 2'b10);
      vecs[4] = mk(1, 4'h3, 32'hA000_0004, 2'b00, 1, 2'b10, 1,  1, 1, 4'h3, 32'hA000_0004, 2'b00, 1, 2'b10);
      vecs[5] = mk(1, 4'h6, 32'hDEAD_BEEF, 2'b01, 1, 2'b11, 0,  1, 0, 4'h6, 32'hDEAD_BEEF, 2'b01, 1, 2'b11);
      vecs[6] = mk(1, 4'h6, 32'hDEAD_BEEF, 2'b01, 1, 2'b11, 1,  1, 1, 4'h6, 32'hDEAD_BEEF, 2'b01, 1, 2'b11);
      vecs[7] = mk(0, 4'h0, 32'h0,         2'b00, 0, 2'b00, 0,  0, 0, 4'h0, 32'h0,         2'b00, 0, 2'b00);

      for (int i = 0; i < 8; i++) begin
         tick();
         drive_m(vecs[i].m_vld, vecs[i].m_id, vecs[i].m_data, vecs[i].m_resp, vecs[i].m_last, vecs[i].m_user);
         s_if.rready = vecs[i].s_rdy;
         #2;
         chk($sformatf("vec%0d rvalid", i), s_if.rvalid, vecs[i].e_vld);
         chk($sformatf("vec%0d mrdy", i),   m_if.rready, vecs[i].e_mrdy);
         chk($sformatf("vec%0d rid", i),    s_if.rid,    vecs[i].e_id);
         chk($sformatf("vec%0d rdata", i),  s_if.rdata,  vecs[i].e_data);
         chk($sformatf("vec%0d rresp", i),  s_if.rresp,  vecs[i].e_resp);
         chk($sformatf("vec%0d rlast", i),  s_if.rlast,  vecs[i].e_last);
         chk($sformatf("vec%0d ruser", i),  s_if.ruser,  vecs[i].e_user);
         chk($sformatf("vec%0d done", i),   drop_done_o, 0);
      end

      // ---------------- single drop, len=0 ----------------
      tick();
      drive_m(1'b0, 4'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      s_if.rready = 1'b1;
      push(4'h5, 8'd0, 2'b01);
      #2 chk("single drop_ready", drop_ready_o, 1);
      tick();
      drop_valid_i = 1'b0;
      #2;
      chk("single cyc1 rvalid", s_if.rvalid, 0);
      chk("single cyc1 mrdy", m_if.rready, 0);
      tick(); #2;
      chk("single rvalid", s_if.rvalid, 1);
      chk("single rid", s_if.rid, 5);
      chk("single rresp", s_if.rresp, 2'b10);
      chk("single rdata", s_if.rdata, 0);
      chk("single rlast", s_if.rlast, 1);
      chk("single ruser", s_if.ruser, 2'b01);
      chk("single mrdy", m_if.rready, 0);
      chk("single done early", drop_done_o, 0);
      tick(); #2;
      chk("single done", drop_done_o, 1);
      chk("single after rvalid", s_if.rvalid, 0);
      tick(); #2;
      chk("single done clear", drop_done_o, 0);

      // ---------------- len=255 with random backpressure ----------------
      tick();
      s_if.rready = 1'b0;
      push(4'h9, 8'd255, 2'b10);
      tick();
      drop_valid_i = 1'b0;
      beats = 0; cyc = 0; got_last = 0;
      while (!got_last && cyc < 3000) begin
         tick();
         s_if.rready = 1'($urandom_range(0, 1));
         #2;
         cyc++;
         chk("long rvalid", s_if.rvalid, 1);
         chk("long rid", s_if.rid, 9);
         chk("long rresp", s_if.rresp, 2'b10);
         chk("long rlast", s_if.rlast, (beats == 255));
         chk("long mrdy", m_if.rready, 0);
         if (s_if.rvalid && s_if.rready) begin
            beats++;
            if (s_if.rlast) got_last = 1;
         end
      end
      chk("long finished", got_last, 1);
      chk("long beats", beats, 256);
      tick(); #2;
      chk("long done", drop_done_o, 1);

      // ---------------- drop pushed during a passthrough burst ----------------
      tick();
      s_if.rready = 1'b1;
      drive_m(1'b1, 4'h2, 32'hB1, 2'b00, 1'b0, 2'b00);
      push(4'h7, 8'd1, 2'b00);
      #2;
      chk("mid beat1 rvalid", s_if.rvalid, 1);
      chk("mid beat1 mrdy", m_if.rready, 1);
      for (int b = 2; b <= 4; b++) begin
         tick();
         drop_valid_i = 1'b0;
         drive_m(1'b1, 4'h2, 32'hB0 + b, 2'b00, (b == 4), 2'b00);
         #2;
         chk($sformatf("mid beat%0d rvalid", b), s_if.rvalid, 1);
         chk($sformatf("mid beat%0d rdata", b), s_if.rdata, 32'hB0 + b);
         chk($sformatf("mid beat%0d mrdy", b), m_if.rready, 1);
      end
      tick();
      drive_m(1'b1, 4'h2, 32'hC0, 2'b00, 1'b0, 2'b00);
      #2;
      chk("mid gap rvalid", s_if.rvalid, 0);
      chk("mid gap mrdy", m_if.rready, 0);
      tick(); #2;
      chk("mid err0 rid", s_if.rid, 7);
      chk("mid err0 rlast", s_if.rlast, 0);
      chk("mid err0 mrdy", m_if.rready, 0);
      tick(); #2;
      chk("mid err1 rid", s_if.rid, 7);
      chk("mid err1 rlast", s_if.rlast, 1);
      chk("mid err1 mrdy", m_if.rready, 0);
      tick(); #2;
      chk("mid done", drop_done_o, 1);
      chk("mid resume rdata", s_if.rdata, 32'hC0);
      chk("mid resume mrdy", m_if.rready, 1);
      tick();
      drive_m(1'b1, 4'h2, 32'hC1, 2'b00, 1'b1, 2'b00);
      tick();
      drive_m(1'b0, 4'h0, 32'h0, 2'b00, 1'b0, 2'b00);

      // ---------------- queue full, FIFO order ----------------
      s_if.rready = 1'b0;
      q_ids   = '{4'd8, 4'd9, 4'd9, 4'd10, 4'd11, 4'd11, 4'd11};
      q_lasts = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         tick();
         push(4'(8 + k), (k == 1) ? 8'd1 : ((k == 3) ? 8'd2 : 8'd0), 2'b00);
         #2 chk($sformatf("full push%0d ready", k), drop_ready_o, 1);
      end
      tick();
      push(4'd12, 8'd0, 2'b00);
      #2 chk("full ready low", drop_ready_o, 0);
      tick();
      drop_valid_i = 1'b0;
      s_if.rready = 1'b1;
      n = 0; cyc = 0; first_c = -1; last_c = -1;
      while (n < 7 && cyc < 60) begin
         #2;
         if (s_if.rvalid && s_if.rready) begin
            chk($sformatf("full beat%0d rid", n), s_if.rid, q_ids[n]);
            chk($sformatf("full beat%0d rlast", n), s_if.rlast, q_lasts[n]);
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
            n++;
         end
         cyc++;
         tick();
      end
      chk("full beat count", n, 7);
      chk("full span", last_c - first_c, 9);
      for (int k = 0; k < 3; k++) begin
         #2 chk("full no fifth", s_if.rvalid, 0);
         tick();
      end

      // ---------------- reset during an error burst ----------------
      s_if.rready = 1'b1;
      push(4'h4, 8'd7, 2'b11);
      tick();
      drop_valid_i = 1'b0;
      tick(); tick(); tick();
      #2;
      chk("rerr pre rvalid", s_if.rvalid, 1);
      chk("rerr pre rid", s_if.rid, 4);
      chk("rerr pre rlast", s_if.rlast, 0);
      axi4_arst = 1'b1;
      drive_m(1'b1, 4'hA, 32'h55, 2'b11, 1'b1, 2'b11);
      #2;
      chk("rerr rvalid", s_if.rvalid, 0);
      chk("rerr rid", s_if.rid, 0);
      chk("rerr rdata", s_if.rdata, 0);
      chk("rerr rresp", s_if.rresp, 0);
      chk("rerr rlast", s_if.rlast, 0);
      chk("rerr ruser", s_if.ruser, 0);
      chk("rerr mrdy", m_if.rready, 0);
      chk("rerr drop_ready", drop_ready_o, 0);
      chk("rerr done", drop_done_o, 0);
      tick(); tick();
      axi4_arst = 1'b0;
      #2;
      chk("rerr post rvalid", s_if.rvalid, 1);
      chk("rerr post rid", s_if.rid, 4'hA);
      chk("rerr post rdata", s_if.rdata, 32'h55);
      chk("rerr post rresp", s_if.rresp, 2'b11);
      chk("rerr post mrdy", m_if.rready, 1);
      chk("rerr post drop_ready", drop_ready_o, 1);
      tick();
      drive_m(1'b0, 4'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      #2 chk("rerr flushed a", s_if.rvalid, 0);
      tick();
      #2 chk("rerr flushed b", s_if.rvalid, 0);
      chk("rerr flushed done", drop_done_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
